fft16_ctrl: RTL
===============

# fft16_ctrl

Sequencing controller for the 16-point radix-2 FFT datapath. It accepts one `start` per transform and collects 16 serial samples, writing each to its bit-reversed address. It then fires the four forward butterfly stages, flags the frequency-domain snapshot, fires the four inverse stages, and streams the 16 time-domain results out with backpressure. It sits between the sample source/sink and the butterfly array, and is the only block that drives the datapath's load, stage and unload controls.

## Interface
Parameters:
- `N_POINTS`, 16: transform length; fixed at 16 in this revision.
- `LOG2N`, 4: number of butterfly stages per direction.
- `STAGE_CYCLES`, 1: cycles each stage occupies; legal range 1–15.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a transform; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; returns the FSM to IDLE.
- `in_valid`  in  1  source has a sample on the data bus.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `load_en`  out  1  datapath writes its input sample register.
- `load_addr`  out  4  bit-reversed write index.
- `stage_en`  out  1  datapath executes butterfly stage `stage_idx`.
- `stage_idx`  out  2  stage number 0–3.
- `inverse`  out  1  selects conjugate twiddles and final 1/N scaling.
- `freq_valid`  out  1  one-cycle pulse; the stage-4 forward result is stable.
- `out_valid`  out  1  result at `out_addr` is presented.
- `out_ready`  in  1  sink accepts the result.
- `out_addr`  out  4  natural-order read index.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, LOAD, FWD, FREQ, INV, UNLOAD, DONE.
- IDLE → LOAD when `start` is high.
- LOAD:
  - `in_ready` = 1.
  - Each cycle with `in_valid && in_ready`: `load_en` = 1, `load_addr` = bitrev(cnt), cnt increments.
  - After the 16th accepted sample → FWD.
- FWD:
  - For s = 0..3: `stage_en` = 1 in the first cycle of the s-th STAGE_CYCLES window, `stage_idx` = s, `inverse` = 0.
  - After stage 3's window ends → FREQ.
- FREQ: one cycle, `freq_valid` = 1 → INV.
- INV: same as FWD with `inverse` = 1; then → UNLOAD.
- UNLOAD:
  - `out_valid` = 1 and `out_addr` = cnt (0..15).
  - cnt advances only on `out_valid && out_ready`.
  - When `out_valid` is high and `out_ready` is low, `out_addr` holds.
  - After index 15 is accepted → DONE.
- DONE: one cycle, `done` = 1 → IDLE.
- `busy` = (state != IDLE).
- Control outputs (`in_ready`, `load_en`, `stage_en`, `freq_valid`, `out_valid`, `done`) are deasserted in every state not listed above.
- `inverse` stays 1 from INV entry until IDLE.
- A single 4-bit counter `cnt` is shared by LOAD, UNLOAD and the stage index; a separate 4-bit timer counts STAGE_CYCLES. Both clear on every state entry.
- `start` outside IDLE is ignored (no queuing).
- `abort` forces IDLE on the next edge with all outputs zero. It has priority over `start` and over every transition.

## Timing
- Reset: state = IDLE, cnt = 0, timer = 0. Every output is 0, including `load_addr`, `stage_idx` and `out_addr`.
- All outputs are registered-state decodes with no combinational path from inputs, except:
  - `load_en` = `in_valid` AND LOAD-state;
  - `out_addr` hold depends on `out_ready` only through cnt.
- Reference schedule (`STAGE_CYCLES` = 1, `in_valid` and `out_ready` constantly high, `start` sampled at edge 0):
  - LOAD cycles 1–16;
  - FWD cycles 17–20;
  - FREQ cycle 21;
  - INV cycles 22–25;
  - UNLOAD cycles 26–41;
  - DONE cycle 42;
  - IDLE from cycle 43.
- General latency from start to `done`: 1 + 16 + 8·STAGE_CYCLES + 1 + 16 + 1 cycles, plus input and output stall cycles.
- Stalls:
  - `in_valid` low in LOAD: no count, no address change.
  - `out_ready` low in UNLOAD: `out_valid` stays high, same `out_addr`.
- `rst` or `abort` mid-operation: the next cycle is IDLE and the partially loaded frame is discarded.
- `start` high on the cycle `done` is high: ignored. A new transform needs `start` in IDLE.
- cnt wraps 15 → 0 exactly on the state exit; it never increments past 15 within a state.

## Structure
- Package `fft16_pkg`:
  - constants `N_POINTS` and `LOG2N`;
  - the state enum `fft16_state_t`;
  - function `bitrev4` for 4-bit bit reversal.
- One natural sub-module: `fft16_stage_timer`. It takes a STAGE_CYCLES window count and a stage counter, and produces `stage_en`, `stage_idx` and `last_stage`. The FSM instantiates it for both FWD and INV.
- The controller holds no data storage; all sample storage stays in the datapath.

## Test plan
- Nominal run: reset, `start`, 16 samples with no stalls.
  - `load_addr` sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - `freq_valid` at cycle 21, `done` at cycle 42, `busy` low at cycle 43.
- Input stalls: drop `in_valid` every other cycle.
  - Exactly 16 `load_en` pulses occur.
  - FWD begins the cycle after the 16th accept.
  - `done` is delayed by 16 cycles (at cycle 58).
- Output backpressure: hold `out_ready` low for 3 cycles at `out_addr` = 5.
  - `out_addr` holds at 5 with `out_valid` high.
  - `done` arrives 3 cycles later (cycle 45).
- `STAGE_CYCLES` = 3:
  - `stage_en` pulses every 3 cycles with `stage_idx` 0,1,2,3, twice;
  - `inverse` = 1 only for the second set;
  - `done` at cycle 58.
- Abort/reset mid-LOAD: assert `abort` after 7 samples.
  - Next cycle is IDLE with all outputs 0.
  - A new `start` restarts with `load_addr` = 0.
  - Repeat the same scenario with `rst` instead of `abort`.
- `start` while busy (at cycles 10 and 42) is ignored: exactly one `done` is produced.

Source files
------------

// File: rtl/fft16_pkg.sv
// Shared constants, state encoding and address helper for the 16-point FFT
// sequencing controller.
package fft16_pkg;

  localparam int N_POINTS = 16;
  localparam int LOG2N    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FWD    = 3'd2,
    ST_FREQ   = 3'd3,
    ST_INV    = 3'd4,
    ST_UNLOAD = 3'd5,
    ST_DONE   = 3'd6
  } fft16_state_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft16_stage_timer.sv
// Butterfly stage decode: turns the shared counter and window timer into
// the per-stage enable pulse, stage index and end-of-pass flag.
module fft16_stage_timer #(
  parameter int STAGE_CYCLES = 1,
  parameter int LOG2N        = fft16_pkg::LOG2N
) (
  input  logic       active,
  input  logic [3:0] cnt,
  input  logic [3:0] timer,
  output logic       stage_en,
  output logic [1:0] stage_idx,
  output logic       window_end,
  output logic       last_stage
);

  // Stage pulse fires only in the first cycle of each window.
  always_comb begin
    stage_en   = 1'b0;
    stage_idx  = 2'd0;
    window_end = 1'b0;
    last_stage = 1'b0;
    if (active) begin
      stage_en   = (timer == 4'd0);
      stage_idx  = cnt[1:0];
      window_end = (timer == 4'(STAGE_CYCLES - 1));
      last_stage = (timer == 4'(STAGE_CYCLES - 1)) && (cnt == 4'(LOG2N - 1));
    end else begin
      stage_en   = 1'b0;
      stage_idx  = 2'd0;
      window_end = 1'b0;
      last_stage = 1'b0;
    end
  end

endmodule

// File: rtl/fft16_ctrl.sv
// Sequencing controller for the 16-point radix-2 FFT datapath: bit-reversed
// load, forward and inverse butterfly passes, and backpressured unload.
module fft16_ctrl #(
  parameter int N_POINTS     = fft16_pkg::N_POINTS,
  parameter int LOG2N        = fft16_pkg::LOG2N,
  parameter int STAGE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_en,
  output logic [3:0] load_addr,
  output logic       stage_en,
  output logic [1:0] stage_idx,
  output logic       inverse,
  output logic       freq_valid,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_addr,
  output logic       busy,
  output logic       done
);

  import fft16_pkg::*;

  fft16_state_t state_r;
  fft16_state_t state_next_s;
  logic [3:0]   cnt_r;
  logic [3:0]   timer_r;
  logic         stage_active_s;
  logic         stage_en_s;
  logic [1:0]   stage_idx_s;
  logic         window_end_s;
  logic         last_stage_s;
  logic         cnt_last_s;

  assign stage_active_s = (state_r == ST_FWD) || (state_r == ST_INV);
  assign cnt_last_s     = (cnt_r == 4'(N_POINTS - 1));

  fft16_stage_timer #(
    .STAGE_CYCLES(STAGE_CYCLES),
    .LOG2N       (LOG2N)
  ) u_stage_timer (
    .active    (stage_active_s),
    .cnt       (cnt_r),
    .timer     (timer_r),
    .stage_en  (stage_en_s),
    .stage_idx (stage_idx_s),
    .window_end(window_end_s),
    .last_stage(last_stage_s)
  );

  // Next-state selection; abort overrides every transition.
  always_comb begin
    state_next_s = state_r;
    if (abort) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_next_s = start ? ST_LOAD : ST_IDLE;
        ST_LOAD:   state_next_s = (in_valid && cnt_last_s) ? ST_FWD : ST_LOAD;
        ST_FWD:    state_next_s = last_stage_s ? ST_FREQ : ST_FWD;
        ST_FREQ:   state_next_s = ST_INV;
        ST_INV:    state_next_s = last_stage_s ? ST_UNLOAD : ST_INV;
        ST_UNLOAD: state_next_s = (out_ready && cnt_last_s) ? ST_DONE : ST_UNLOAD;
        ST_DONE:   state_next_s = ST_IDLE;
        default:   state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register plus shared counter/timer, both cleared on any state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      timer_r <= 4'd0;
    end else if (state_next_s != state_r) begin
      state_r <= state_next_s;
      cnt_r   <= 4'd0;
      timer_r <= 4'd0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (in_valid) cnt_r <= cnt_r + 4'd1;
        end
        ST_UNLOAD: begin
          if (out_ready) cnt_r <= cnt_r + 4'd1;
        end
        ST_FWD, ST_INV: begin
          if (window_end_s) begin
            cnt_r   <= cnt_r + 4'd1;
            timer_r <= 4'd0;
          end else begin
            timer_r <= timer_r + 4'd1;
          end
        end
        default: begin
          cnt_r   <= cnt_r;
          timer_r <= timer_r;
        end
      endcase
    end
  end

  // Output decode from registered state; load_en is the only input-qualified output.
  always_comb begin
    in_ready   = 1'b0;
    load_en    = 1'b0;
    load_addr  = 4'd0;
    stage_en   = stage_en_s;
    stage_idx  = stage_idx_s;
    inverse    = 1'b0;
    freq_valid = 1'b0;
    out_valid  = 1'b0;
    out_addr   = 4'd0;
    busy       = (state_r != ST_IDLE);
    done       = 1'b0;
    case (state_r)
      ST_LOAD: begin
        in_ready  = 1'b1;
        load_en   = in_valid;
        load_addr = bitrev4(cnt_r);
      end
      ST_FREQ:   freq_valid = 1'b1;
      ST_INV:    inverse = 1'b1;
      ST_UNLOAD: begin
        inverse   = 1'b1;
        out_valid = 1'b1;
        out_addr  = cnt_r;
      end
      ST_DONE: begin
        inverse = 1'b1;
        done    = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule
